// File: rtl/seq_detect_step_ctrl.sv
// rtl/seq_detect_step_ctrl.sv - stepped "00->10->11" sequence detector with synchronized,
// debounced switch/button inputs, manual or auto stepping and a saturating detection counter.
module seq_detect_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_DIV        = 100000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_x2,
  input  logic             sw_x1,
  input  logic             btn_step,
  input  logic             sw_auto,
  output logic [1:0]       led_state,
  output logic             led_z,
  output logic             led_step,
  output logic [CNT_W-1:0] det_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(AUTO_DIV);

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  logic [2:0]       db_q, db_d;
  logic [DW-1:0]    db_cnt_q [3];
  logic [DW-1:0]    db_cnt_d [3];
  logic             btn_prev_q;
  logic [TW-1:0]    tick_q, tick_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       nstate;
  logic             step_q;
  logic [CNT_W-1:0] det_q, det_d;
  logic             auto_mode, manual_step, auto_tick, step;
  logic             x1, x2, y1, y2;

  // Bit order: 0=x1, 1=x2, 2=button (debounced), 3=auto mode (synchronized only).
  assign raw       = {sw_auto, btn_step, sw_x2, sw_x1};
  assign auto_mode = sync2_q[3];
  assign x1        = db_q[0];
  assign x2        = db_q[1];
  assign y1        = state_q[0];
  assign y2        = state_q[1];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Manual edges are ignored in auto mode, so at most one step source is live per cycle.
  always_comb begin
    tick_d    = '0;
    auto_tick = 1'b0;
    if (auto_mode) begin
      if (tick_q == TW'(AUTO_DIV - 1)) begin
        auto_tick = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  assign manual_step = db_q[2] & ~btn_prev_q & ~auto_mode;
  assign step        = manual_step | auto_tick;

  assign nstate[0] = x1 | (x2 & y1);
  assign nstate[1] = (x2 & ~x1 & ~y1) | (x1 & x2 & y2);

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    if (step) begin
      state_d = nstate;
      if ((nstate == 2'b11) && (state_q != 2'b11) && (det_q != {CNT_W{1'b1}})) begin
        det_d = det_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      btn_prev_q <= 1'b0;
      tick_q     <= '0;
      state_q    <= 2'b00;
      step_q     <= 1'b0;
      det_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      btn_prev_q <= db_q[2];
      tick_q     <= tick_d;
      state_q    <= state_d;
      step_q     <= step;
      det_q      <= det_d;
    end
  end

  assign led_state = state_q;
  assign led_z     = y2 & y1;
  assign led_step  = step_q;
  assign det_count = det_q;

endmodule
